// File: rtl/memory_walk_controller_pkg.sv
// Shared definitions for the memory walk controller: sizes, FSM state
// encoding, memory status codes and a range helper.
package memory_walk_controller_pkg;

  localparam int WORD_SIZE    = 32;
  localparam int ADDRESS_SIZE = 8;
  localparam int WORDS_NUMBER = 8;
  localparam int COUNT_SIZE   = 8;

  // Memory Status pin values
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Word-wide copy of the word count for full-width range compares
  localparam logic [WORD_SIZE-1:0] WORDS_NUMBER_W = WORD_SIZE'(WORDS_NUMBER);

  // Address of the last implemented word (end of a bulk load)
  localparam logic [ADDRESS_SIZE-1:0] LAST_WORD_ADDR = ADDRESS_SIZE'(WORDS_NUMBER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WALK = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // A fetched word is a usable pointer only if the whole word addresses an
  // implemented location; upper bits being set counts as out of range.
  function automatic logic word_is_pointer(input logic [WORD_SIZE-1:0] word);
    return (word < WORDS_NUMBER_W);
  endfunction

endpackage

// File: rtl/memory_walk_controller_if.sv
// Host-side control/step stream and Memory pin bundle of the walk controller.
// master: the controller view (drives step stream and Memory pins).
// slave:  the environment view (host requester plus the Memory instance).
interface memory_walk_controller_if;
  import memory_walk_controller_pkg::*;

  logic                    start;
  logic                    mode;
  logic [ADDRESS_SIZE-1:0] start_address;
  logic [COUNT_SIZE-1:0]   step_limit;
  logic [WORD_SIZE-1:0]    load_data;
  logic                    load_valid;
  logic                    load_ready;
  logic                    step_valid;
  logic [ADDRESS_SIZE-1:0] step_address;
  logic [WORD_SIZE-1:0]    step_data;
  logic                    busy;
  logic                    done;
  logic                    error;
  logic                    mem_status;
  logic [ADDRESS_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0]    mem_i;
  logic [WORD_SIZE-1:0]    mem_q;

  modport master (
    input  start, mode, start_address, step_limit, load_data, load_valid, mem_q,
    output load_ready, step_valid, step_address, step_data, busy, done, error,
           mem_status, mem_address, mem_i
  );

  modport slave (
    output start, mode, start_address, step_limit, load_data, load_valid, mem_q,
    input  load_ready, step_valid, step_address, step_data, busy, done, error,
           mem_status, mem_address, mem_i
  );

endinterface

// File: rtl/memory_walk_controller_walk_step_check.sv
// Per-step decision for a pointer walk: next address, out-of-range pointer
// and whether this step is the last one (limit reached or back at start).
module walk_step_check
  import memory_walk_controller_pkg::*;
(
  input  logic [WORD_SIZE-1:0]    mem_q,
  input  logic [COUNT_SIZE-1:0]   count,
  input  logic [COUNT_SIZE-1:0]   step_limit,
  input  logic [ADDRESS_SIZE-1:0] start_address,
  output logic [ADDRESS_SIZE-1:0] nxt,
  output logic [COUNT_SIZE-1:0]   count_next,
  output logic                    out_of_range,
  output logic                    finish
);

  localparam logic [COUNT_SIZE-1:0] COUNT_ONE = {{(COUNT_SIZE-1){1'b0}}, 1'b1};

  logic limit_hit_s;
  logic loop_hit_s;

  // Derive next pointer and the termination conditions from the fetched word
  always_comb begin
    nxt          = mem_q[ADDRESS_SIZE-1:0];
    count_next   = count + COUNT_ONE;
    out_of_range = ~word_is_pointer(mem_q);
    limit_hit_s  = (count_next == step_limit);
    loop_hit_s   = (mem_q[ADDRESS_SIZE-1:0] == start_address);
    if (limit_hit_s || loop_hit_s) begin
      finish = 1'b1;
    end else begin
      finish = 1'b0;
    end
  end

endmodule

// File: rtl/memory_walk_controller.sv
// Sequencer owning a single-port word memory: bulk load from a stream, or
// pointer-chase walk reporting one visited address/data pair per cycle.
module memory_walk_controller
  import memory_walk_controller_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  memory_walk_controller_if.master  bus
);

  localparam logic [ADDRESS_SIZE-1:0] ADDR_ONE  = {{(ADDRESS_SIZE-1){1'b0}}, 1'b1};
  localparam logic [ADDRESS_SIZE-1:0] ADDR_ZERO = {ADDRESS_SIZE{1'b0}};
  localparam logic [COUNT_SIZE-1:0]   CNT_ZERO  = {COUNT_SIZE{1'b0}};
  localparam logic [WORD_SIZE-1:0]    WORD_ZERO = {WORD_SIZE{1'b0}};

  state_t                  state_r;
  logic [ADDRESS_SIZE-1:0] load_ptr_r;
  logic [ADDRESS_SIZE-1:0] cur_r;
  logic [ADDRESS_SIZE-1:0] start_addr_r;
  logic [COUNT_SIZE-1:0]   step_limit_r;
  logic [COUNT_SIZE-1:0]   count_r;
  logic                    step_valid_r;
  logic [ADDRESS_SIZE-1:0] step_address_r;
  logic [WORD_SIZE-1:0]    step_data_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    error_r;
  logic                    load_ready_r;

  logic [ADDRESS_SIZE-1:0] nxt_s;
  logic [COUNT_SIZE-1:0]   count_next_s;
  logic                    out_of_range_s;
  logic                    finish_s;

  walk_step_check u_walk_step_check (
    .mem_q         (bus.mem_q),
    .count         (count_r),
    .step_limit    (step_limit_r),
    .start_address (start_addr_r),
    .nxt           (nxt_s),
    .count_next    (count_next_s),
    .out_of_range  (out_of_range_s),
    .finish        (finish_s)
  );

  // Main sequencer: state, pointers and all registered host-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      load_ptr_r     <= ADDR_ZERO;
      cur_r          <= ADDR_ZERO;
      start_addr_r   <= ADDR_ZERO;
      step_limit_r   <= CNT_ZERO;
      count_r        <= CNT_ZERO;
      step_valid_r   <= 1'b0;
      step_address_r <= ADDR_ZERO;
      step_data_r    <= WORD_ZERO;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      load_ready_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r       <= 1'b0;
          step_valid_r <= 1'b0;
          if (bus.start) begin
            if (!bus.mode) begin
              state_r      <= ST_LOAD;
              load_ptr_r   <= ADDR_ZERO;
              load_ready_r <= 1'b1;
              busy_r       <= 1'b1;
            end else begin
              start_addr_r <= bus.start_address;
              step_limit_r <= bus.step_limit;
              cur_r        <= bus.start_address;
              count_r      <= CNT_ZERO;
              error_r      <= 1'b0;
              // A zero step limit finishes without touching memory
              if (bus.step_limit == CNT_ZERO) begin
                state_r <= ST_DONE;
              end else begin
                state_r <= ST_WALK;
                busy_r  <= 1'b1;
              end
            end
          end
        end
        ST_LOAD: begin
          if (bus.load_valid) begin
            load_ptr_r <= load_ptr_r + ADDR_ONE;
            if (load_ptr_r == LAST_WORD_ADDR) begin
              state_r      <= ST_DONE;
              load_ready_r <= 1'b0;
              busy_r       <= 1'b0;
            end
          end
        end
        ST_WALK: begin
          step_valid_r   <= 1'b1;
          step_address_r <= cur_r;
          step_data_r    <= bus.mem_q;
          count_r        <= count_next_s;
          if (out_of_range_s) begin
            error_r <= 1'b1;
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
          end else if (finish_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
          end else begin
            cur_r <= nxt_s;
          end
        end
        ST_DONE: begin
          // Last step drains here; Done pulses in the following IDLE cycle
          step_valid_r <= 1'b0;
          done_r       <= 1'b1;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          step_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
          load_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Memory pins follow the state; the load path passes the stream straight
  // through so a word is written on the edge that accepts it
  always_comb begin
    bus.mem_status  = MEM_READ;
    bus.mem_address = ADDR_ZERO;
    bus.mem_i       = WORD_ZERO;
    case (state_r)
      ST_LOAD: begin
        bus.mem_status  = bus.load_valid ? MEM_WRITE : MEM_READ;
        bus.mem_address = load_ptr_r;
        bus.mem_i       = bus.load_data;
      end
      ST_WALK: begin
        bus.mem_status  = MEM_READ;
        bus.mem_address = cur_r;
        bus.mem_i       = WORD_ZERO;
      end
      default: begin
        bus.mem_status  = MEM_READ;
        bus.mem_address = ADDR_ZERO;
        bus.mem_i       = WORD_ZERO;
      end
    endcase
  end

  // Host-side outputs come straight from their registers
  always_comb begin
    bus.load_ready   = load_ready_r;
    bus.step_valid   = step_valid_r;
    bus.step_address = step_address_r;
    bus.step_data    = step_data_r;
    bus.busy         = busy_r;
    bus.done         = done_r;
    bus.error        = error_r;
  end

endmodule

// File: tb/tb_memory_walk_controller.sv
// Directed bench for memory_walk_controller with a behavioural word memory
// (combinational read, write on rising edge when Status is high).
module tb_memory_walk_controller;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  memory_walk_controller_if bus ();

  memory_walk_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:7];
  logic [31:0] load_words [0:7];
  int          exp_a[$];
  int          exp_d[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Memory: asynchronous read, synchronous write
  always_comb begin
    if (bus.mem_address < 8'd8) bus.mem_q = mem[bus.mem_address[2:0]];
    else bus.mem_q = 32'd0;
  end

  always @(posedge clk) begin
    if (bus.mem_status && (bus.mem_address < 8'd8)) mem[bus.mem_address[2:0]] <= bus.mem_i;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_step_valid"}, {31'd0, bus.step_valid}, 32'd0);
    check_eq({tag, "_step_addr"}, {24'd0, bus.step_address}, 32'd0);
    check_eq({tag, "_step_data"}, bus.step_data, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check_eq({tag, "_error"}, {31'd0, bus.error}, 32'd0);
    check_eq({tag, "_load_ready"}, {31'd0, bus.load_ready}, 32'd0);
    check_eq({tag, "_mem_status"}, {31'd0, bus.mem_status}, 32'd0);
    check_eq({tag, "_mem_addr"}, {24'd0, bus.mem_address}, 32'd0);
    check_eq({tag, "_mem_i"}, bus.mem_i, 32'd0);
  endtask

  // Load all eight words; optionally drop LoadValid once at index stall_at
  task automatic run_load(input int stall_at);
    int idx = 0;
    int lr = 0;
    bit stalled = 1'b0;
    bit seen_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 30 && !seen_done; c++) begin
      if (bus.load_ready && idx < 8) begin
        lr++;
        if (idx == stall_at && !stalled) begin
          stalled = 1'b1;
          bus.load_valid = 1'b0;
          #1;
          check_eq("load_stall_status", {31'd0, bus.mem_status}, 32'd0);
        end else begin
          bus.load_valid = 1'b1;
          bus.load_data  = load_words[idx];
          #1;
          check_eq("load_status", {31'd0, bus.mem_status}, 32'd1);
          check_eq("load_addr", {24'd0, bus.mem_address}, idx);
          check_eq("load_mem_i", bus.mem_i, load_words[idx]);
          idx++;
        end
      end else begin
        bus.load_valid = 1'b0;
      end
      if (bus.done) seen_done = 1'b1;
      else @(negedge clk);
    end
    bus.load_valid = 1'b0;
    check_eq("load_done", {31'd0, seen_done}, 32'd1);
    check_eq("load_words", idx, 32'd8);
    check_eq("load_ready_cycles", lr, (stall_at < 8) ? 32'd9 : 32'd8);
    for (int i = 0; i < 8; i++) check_eq("load_mem", mem[i], load_words[i]);
    @(negedge clk);
    check_eq("load_done_pulse", {31'd0, bus.done}, 32'd0);
  endtask

  // Start a walk and compare every reported step against exp_a/exp_d
  task automatic run_walk(input logic [7:0] sa, input logic [7:0] lim,
                          input logic exp_err, input bit poke_start);
    int steps = 0;
    bit seen_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 1'b1;
    bus.start_address = sa;
    bus.step_limit = lim;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("walk_busy", {31'd0, bus.busy}, (lim != 8'd0) ? 32'd1 : 32'd0);
    check_eq("walk_err_clear", {31'd0, bus.error}, 32'd0);
    if (poke_start) begin
      bus.start = 1'b1;
      bus.mode = 1'b0;
    end
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (c == 1) bus.start = 1'b0;
      if (bus.step_valid) begin
        if (steps < exp_a.size()) begin
          check_eq("step_addr", {24'd0, bus.step_address}, exp_a[steps]);
          check_eq("step_data", bus.step_data, exp_d[steps]);
        end
        check_eq("step_done_overlap", {31'd0, bus.done}, 32'd0);
        steps++;
      end
      if (bus.done) seen_done = 1'b1;
      else @(negedge clk);
    end
    bus.start = 1'b0;
    check_eq("walk_done", {31'd0, seen_done}, 32'd1);
    check_eq("walk_steps", steps, exp_a.size());
    check_eq("walk_error", {31'd0, bus.error}, {31'd0, exp_err});
    @(negedge clk);
    check_eq("walk_done_pulse", {31'd0, bus.done}, 32'd0);
    check_eq("walk_busy_end", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.start_address = 8'd0;
    bus.step_limit = 8'd0;
    bus.load_data = 32'd0;
    bus.load_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    // Bulk load 4,1,3,4,2,5,6,0 with LoadValid held
    load_words = '{32'd4, 32'd1, 32'd3, 32'd4, 32'd2, 32'd5, 32'd6, 32'd0};
    run_load(99);

    // Walk from 0 for six steps around the 4->2->3 cycle
    exp_a = '{0, 4, 2, 3, 4, 2};
    exp_d = '{4, 2, 3, 4, 2, 3};
    run_walk(8'd0, 8'd6, 1'b0, 1'b0);

    // Self loop at 5 stops after one step
    exp_a = '{5};
    exp_d = '{5};
    run_walk(8'd5, 8'd10, 1'b0, 1'b0);

    // Limit of three from 7, with a Start pulse during the walk ignored
    exp_a = '{7, 0, 4};
    exp_d = '{0, 4, 2};
    run_walk(8'd7, 8'd3, 1'b0, 1'b1);

    // Zero step limit: Done without any step
    exp_a = {};
    exp_d = {};
    run_walk(8'd3, 8'd0, 1'b0, 1'b0);

    // Reload with word 1 = 9 (one stall cycle) and walk into it
    load_words = '{32'd4, 32'd9, 32'd3, 32'd4, 32'd2, 32'd5, 32'd6, 32'd0};
    run_load(3);
    exp_a = '{1};
    exp_d = '{9};
    run_walk(8'd1, 8'd5, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("error_sticky", {31'd0, bus.error}, 32'd1);

    // Next Start clears Error
    exp_a = '{0};
    exp_d = '{4};
    run_walk(8'd0, 8'd1, 1'b0, 1'b0);

    // Reset in the middle of a walk aborts without Done
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 1'b1;
    bus.start_address = 8'd0;
    bus.step_limit = 8'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("midwalk_valid", {31'd0, bus.step_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("midwalk_reset");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("no_done_after_reset", {31'd0, bus.done | bus.step_valid}, 32'd0);
    end
    for (int i = 0; i < 8; i++) check_eq("mem_kept", mem[i], load_words[i]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
